// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions.
//   XLEN          : architectural register / address width
//   INSTR_NOP     : canonical NOP (addi x0, x0, 0), shown when no instruction is presented
//   fetch_entry_t : {pc, instr} pair held in the instruction queue
//   word_align()  : clears the byte-offset bits of a fetch address
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a synchronous clear, used for the instruction queue and
// for the queue of outstanding fetch addresses.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : drop all entries (wins over push/pop in the same cycle)
//   push_i    : write wdata_i at the tail (ignored when full unless popping)
//   pop_i     : advance the head (ignored when empty)
//   rdata_o   : head entry, read combinationally
//   count_o   : number of valid entries
//   empty_o   : no valid entries
//   full_o    : DEPTH valid entries
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // When full, a simultaneous pop frees the slot being written.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end ahead of the IF/ID register. Issues word-aligned
// fetch requests to a variable-latency instruction memory, buffers returned
// {pc, instr} pairs and hands them to decode over a valid/ready handshake.
// A redirect flushes everything buffered and discards responses still in flight.
//   clk, rst                      : clock, synchronous active-high reset
//   redirect_valid, redirect_pc   : new fetch stream from EX/MEM (bits [1:0] ignored)
//   imem_req_valid/ready/addr     : fetch request channel
//   imem_rsp_valid/data           : in-order fetch responses
//   out_valid/ready               : head-of-queue handshake toward decode
//   out_pc, out_pc_plus_4, out_instr : head entry
module if_fetch_queue
  import rv_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [31:0] out_instr
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PCW-1:0]  live_cnt_q, live_cnt_d;
  logic [PCW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PCW-1:0]  inflight_cnt;

  logic [31:0]     inflight_sum, occupancy_sum;
  logic            credit_ok;
  logic            req_fire, rsp_live, rsp_drop, out_fire;

  logic [QCW-1:0]  iq_count;
  logic            iq_empty, iq_full;
  fetch_entry_t    iq_wentry, iq_head;

  logic [XLEN-1:0] pend_addr;
  logic [PCW-1:0]  pend_count;
  logic            pend_empty, pend_full;
  logic            unused_ok;

  // Credits: every live request owns a queue slot, so a response can always be
  // accepted, and dropped responses still count against the memory's capacity.
  assign inflight_sum  = 32'(live_cnt_q) + 32'(drop_cnt_q);
  assign occupancy_sum = 32'(live_cnt_q) + 32'(iq_count);
  assign credit_ok     = (inflight_sum < MAX_OUTSTANDING) && (occupancy_sum < DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && credit_ok && !pend_full;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are in request order, so the oldest drop_cnt responses are the
  // stale ones from before the last redirect.
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_live = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid && !pend_empty;

  assign out_valid = !rst && !iq_empty;
  assign out_fire  = out_valid && out_ready && !redirect_valid;

  assign iq_wentry = '{pc: pend_addr, instr: imem_rsp_data};

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect_valid),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_live),
    .rdata_o (pend_addr),
    .count_o (pend_count),
    .empty_o (pend_empty),
    .full_o  (pend_full)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect_valid),
    .push_i  (rsp_live),
    .wdata_i (iq_wentry),
    .pop_i   (out_fire),
    .rdata_o (iq_head),
    .count_o (iq_count),
    .empty_o (iq_empty),
    .full_o  (iq_full)
  );

  assign out_pc        = iq_head.pc;
  assign out_pc_plus_4 = iq_head.pc + 32'd4;
  assign out_instr     = out_valid ? iq_head.instr : INSTR_NOP;

  assign inflight_cnt = live_cnt_q + drop_cnt_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    live_cnt_d = live_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      live_cnt_d = '0;
      // Everything still owed by memory becomes stale; a response arriving
      // this very cycle is one of them and is already being thrown away.
      if (imem_rsp_valid && (inflight_cnt != '0)) drop_cnt_d = inflight_cnt - PCW'(1);
      else                                         drop_cnt_d = inflight_cnt;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      case ({req_fire, rsp_live})
        2'b10:   live_cnt_d = live_cnt_q + PCW'(1);
        2'b01:   live_cnt_d = live_cnt_q - PCW'(1);
        default: live_cnt_d = live_cnt_q;
      endcase
      if (rsp_drop) drop_cnt_d = drop_cnt_q - PCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      live_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      live_cnt_q <= live_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Occupancy of the pending queue is tracked by live_cnt_q, and the credit
  // rule keeps the instruction queue from ever being pushed while full.
  assign unused_ok = &{1'b0, pend_count, iq_full};

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_pc_plus_4, out_instr;

  if_fetch_queue #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus_4  (out_pc_plus_4),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        ordy;
    logic        rv;
    logic [31:0] ra;
    logic        ov;
    logic [31:0] op;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  mem_t        mem_q[$];
  exp_t        exp_q[$];
  vec_t        tbl[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] model_pc = RESET_PC;
  bit          acc_seen = 0;
  logic [31:0] acc_addr = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + 32'h0000_1000;
  endfunction

  function automatic vec_t mkv(input logic r, input logic o, input logic v,
                               input logic [31:0] a, input logic ov, input logic [31:0] p);
    vec_t t;
    t = '{rst: r, ordy: o, rv: v, ra: a, ov: ov, op: p};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Called at the negedge: outputs are settled for the current cycle.
  task automatic observe();
    exp_t e;
    acc_seen = 0;
    if (rst) begin
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      exp_q.delete();
      mem_q.delete();
      model_pc = RESET_PC;
      return;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now($sformatf("out_unexpected: got pc %h with nothing outstanding", out_pc));
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_pc_plus_4", out_pc_plus_4, e.pc + 32'd4);
        chk("out_instr", out_instr, e.instr);
      end
    end
    if (redirect_valid) chk("req_during_redirect", {31'b0, imem_req_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, model_pc);
      acc_seen = 1;
      acc_addr = imem_req_addr;
      exp_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  // Crosses the active edge and drives the memory response for the next cycle.
  task automatic advance();
    mem_t m;
    @(posedge clk);
    #1;
    if (acc_seen) mem_q.push_back('{addr: acc_addr, due: cyc + lat});
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(m.addr);
    end
  endtask

  task automatic nxt();
    observe();
    advance();
  endtask

  task automatic cyc1();
    @(negedge clk);
    nxt();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    cyc1();
    rst = 1'b0;
  endtask

  // Leaves the caller at the negedge of the cycle where out_valid is high.
  task automatic wait_out(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
      nxt();
    end
    if (!ok) fail_now($sformatf("%s: timeout waiting for out_valid", name));
  endtask

  task automatic wait_req(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        ok = 1;
        break;
      end
      nxt();
    end
    if (!ok) fail_now($sformatf("%s: timeout waiting for imem_req_valid", name));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          n;
    logic [31:0] got [3];

    // Zero-wait memory, free-running decode.
    tbl.push_back(mkv(1, 1, 0, 32'h0,  0, 32'h0));
    tbl.push_back(mkv(0, 1, 1, 32'h0,  0, 32'h0));
    tbl.push_back(mkv(0, 1, 1, 32'h4,  0, 32'h0));
    tbl.push_back(mkv(0, 1, 1, 32'h8,  1, 32'h0));
    tbl.push_back(mkv(0, 1, 1, 32'hC,  1, 32'h4));
    tbl.push_back(mkv(0, 1, 1, 32'h10, 1, 32'h8));
    // Decode stalled for 10 cycles: queue fills with 0x0..0xC, then fetch stops.
    tbl.push_back(mkv(1, 0, 0, 32'h0,  0, 32'h0));
    tbl.push_back(mkv(0, 0, 1, 32'h0,  0, 32'h0));
    tbl.push_back(mkv(0, 0, 1, 32'h4,  0, 32'h0));
    tbl.push_back(mkv(0, 0, 1, 32'h8,  1, 32'h0));
    tbl.push_back(mkv(0, 0, 1, 32'hC,  1, 32'h0));
    for (int k = 4; k < 10; k++) tbl.push_back(mkv(0, 0, 0, 32'h0, 1, 32'h0));
    tbl.push_back(mkv(0, 1, 0, 32'h0,  1, 32'h0));
    tbl.push_back(mkv(0, 1, 1, 32'h10, 1, 32'h4));
    tbl.push_back(mkv(0, 1, 1, 32'h14, 1, 32'h8));
    tbl.push_back(mkv(0, 1, 1, 32'h18, 1, 32'hC));
    tbl.push_back(mkv(0, 1, 1, 32'h1C, 1, 32'h10));

    cyc1();
    lat = 1;
    imem_req_ready = 1'b1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      if (!tbl[i].rst) begin
        chk($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].rv});
        if (tbl[i].rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].ra);
        chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
        if (tbl[i].ov) chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].op);
      end
      nxt();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cyc1();

    // Redirect with two slow responses in flight.
    do_reset();
    lat = 3;
    cyc1();
    cyc1();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    cyc1();
    redirect_valid = 1'b0;
    wait_req("t3_first_req", ok);
    if (ok) begin
      chk("t3_first_req_addr", imem_req_addr, 32'h0000_0100);
      nxt();
    end
    wait_out("t3_first_out", ok);
    if (ok) begin
      chk("t3_first_out_pc", out_pc, 32'h0000_0100);
      nxt();
    end
    for (int k = 0; k < 6; k++) cyc1();

    // Redirect coinciding with a live response and a decode handshake.
    do_reset();
    lat = 1;
    for (int k = 0; k < 5; k++) cyc1();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc1();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_flushed_out_valid", {31'b0, out_valid}, 32'd0);
    nxt();
    wait_out("t4_first_out", ok);
    if (ok) begin
      chk("t4_first_out_pc", out_pc, 32'h0000_0200);
      nxt();
    end
    for (int k = 0; k < 6; k++) cyc1();

    // Memory back-pressure holds the request steady.
    do_reset();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5_hold%0d_valid", k), {31'b0, imem_req_valid}, 32'd1);
      chk($sformatf("t5_hold%0d_addr", k), imem_req_addr, RESET_PC);
      nxt();
    end
    imem_req_ready = 1'b1;
    wait_out("t5_first_out", ok);
    if (ok) begin
      chk("t5_first_out_pc", out_pc, RESET_PC);
      nxt();
    end
    for (int k = 0; k < 6; k++) cyc1();

    // Address wrap at the top of memory, then reset mid-stream.
    do_reset();
    for (int k = 0; k < 4; k++) cyc1();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFA;
    cyc1();
    redirect_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got[n] = out_pc;
        n++;
      end
      nxt();
    end
    if (n < 3) begin
      fail_now($sformatf("t6_wrap: only %0d instructions delivered, need 3", n));
    end else begin
      chk("t6_wrap_pc0", got[0], 32'hFFFF_FFF8);
      chk("t6_wrap_pc1", got[1], 32'hFFFF_FFFC);
      chk("t6_wrap_pc2", got[2], 32'h0000_0000);
    end
    cyc1();
    do_reset();
    @(negedge clk);
    chk("t6_post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_post_rst_req_addr", imem_req_addr, RESET_PC);
    nxt();
    wait_out("t6_post_rst_out", ok);
    if (ok) begin
      chk("t6_post_rst_out_pc", out_pc, RESET_PC);
      nxt();
    end
    for (int k = 0; k < 4; k++) cyc1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch front end that sits upstream of the IF/ID pipeline register. It replaces the direct PC-to-instruction-memory path with a request/response interface to a variable-latency instruction memory, and buffers fetched {pc, instr} pairs in a small queue. It presents them to decode through a valid/ready handshake. Branch/jump redirects from the EX/MEM stage flush the queue and discard in-flight responses.

Parameters:
DEPTH, 4, entries in the instruction queue (power of 2, ≥2)
MAX_OUTSTANDING, 2, max imem requests in flight (live + to-be-dropped), ≥1
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
redirect_valid  input  1  redirect fetch (taken branch/jump or flush)
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  instruction returned, in request order, ≥1 cycle after acceptance
imem_rsp_data  input  32  returned instruction
out_valid  output  1  queue head valid toward IF/ID
out_ready  input  1  decode accepts head (low = hazard stall)
out_pc  output  32  PC of head instruction
out_pc_plus_4  output  32  out_pc + 4, modulo 2^32
out_instr  output  32  head instruction

Behaviour:
- Reset state: fetch_pc=RESET_PC, queue empty, live_cnt=0, drop_cnt=0. During the rst cycle: imem_req_valid=0, out_valid=0. The first request can issue in the first cycle after rst deasserts.
- Credit rule: imem_req_valid = !redirect_valid && (live_cnt + drop_cnt < MAX_OUTSTANDING) && (live_cnt + count < DEPTH). Every live response therefore has a guaranteed queue slot, and push-while-full is impossible.
- imem_req_addr = fetch_pc, held stable while valid && !ready.
- Request acceptance (valid && ready): fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0), live_cnt++. Accepted address is pushed into the pending-address queue (depth MAX_OUTSTANDING).
- Response handling, with no redirect in the same cycle:
  - If drop_cnt>0: data discarded, drop_cnt--.
  - Otherwise: pop the pending address, push {addr, data} into the instruction queue, live_cnt--.
  - Dropped entries are never pushed into the pending queue.
- Output: out_valid = (count != 0). out_* are driven from the head entry, combinationally from queue state. Pop on out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- Redirect cycle (highest priority, overrides push/pop/request):
  - Instruction queue and pending queue cleared.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt_next = drop_cnt + live_cnt − (imem_rsp_valid ? 1 : 0); any response in that cycle is discarded.
  - live_cnt=0.
  - No request is issued. out_valid is 0 from the next cycle until a new live response arrives.
- Back-to-back redirects: each recomputes drop_cnt from current counts. The last redirect_pc wins.
- Reset during in-flight requests: all state reinitialises. The memory is also reset, so no dropping is carried across reset.
- Latency: with a zero-wait memory (rsp one cycle after acceptance), steady-state throughput is 1 instr/cycle when MAX_OUTSTANDING ≥ 2. The first instruction appears at out_valid 2 cycles after rst deasserts.
- No combinational path from imem_rsp_* to out_*: data is registered through the queue.

Decomposition:
- Shared package rv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, and a fetch entry struct {pc[31:0], instr[31:0]}.
- One natural sub-module: sync_fifo (parameterised WIDTH, DEPTH, with synchronous clear). It is instantiated twice: as the instruction queue (WIDTH 64) and as the pending-address queue (WIDTH 32, DEPTH MAX_OUTSTANDING).
- Counters and credit logic stay in the top of if_fetch_queue.

Test Plan:
1. Zero-wait memory, out_ready=1, rst released at cycle 0 → requests 0x0,0x4,0x8… on consecutive cycles; out_pc 0x0 at cycle 2, then +4 every cycle; out_pc_plus_4=out_pc+4.
2. out_ready=0 for 10 cycles → exactly DEPTH=4 entries (0x0–0xC) buffered, imem_req_valid drops to 0. Release → entries drain in order with no loss or duplicates, then fetch resumes at 0x10.
3. 3-cycle memory latency, two requests in flight (0x0,0x4), redirect_pc=0x103 asserted → both responses discarded, next request addr=0x100, first out_pc=0x100.
4. Redirect in the same cycle as a response and an out handshake → that response is dropped, queue empty next cycle, drop_cnt is correct (no stale instruction ever appears at out_*).
5. imem_req_ready held 0 for 5 cycles → imem_req_addr stays 0x0 and imem_req_valid stays 1 throughout; after ready, fetch_pc advances by 4 once per acceptance.
6. Redirect to 0xFFFF_FFF8 → fetched PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst asserted mid-stream → next cycle out_valid=0, then fetch restarts at RESET_PC.
